// File: rtl/row_mac_sequencer.sv
// Matrix x vector stage: pops a size x size matrix from a FIFO and emits one dot product per row.
// Optional result clamping is enabled by defining ROW_MAC_SAT_EN.
module row_mac_sequencer #(
    parameter int DW    = 8,
    parameter int N     = 4,
    parameter int RES_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [$clog2(N+1)-1:0] mat_size,
    input  logic                   vec_wr,
    input  logic [$clog2(N)-1:0]   vec_idx,
    input  logic [DW-1:0]          vec_data,
    input  logic                   fifo_empty,
    input  logic [DW-1:0]          fifo_data,
    output logic                   fifo_pop,
    output logic                   res_valid,
    output logic [RES_W-1:0]       res_data,
    output logic [$clog2(N)-1:0]   res_idx,
    output logic                   res_sat,
    output logic                   busy,
    output logic                   done
);
    localparam int ACC_W = 2*DW + $clog2(N);
    localparam int SW    = $clog2(N+1);
    localparam int IW    = $clog2(N);
    localparam int PW    = 2*SW;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t           state;
    logic [SW-1:0]    size_r;
    logic [PW-1:0]    pops;
    logic [PW-1:0]    total;
    logic [IW-1:0]    col, row, col_d, row_d;
    logic             pop_d;
    logic [DW-1:0]    vec [N];
    logic [ACC_W-1:0] acc, prod, sum;
    logic             last_col, last_col_d;
    logic [RES_W-1:0] res_next;
    logic             sat_next;

    always_comb begin
        total      = PW'(size_r) * PW'(size_r);
        fifo_pop   = (state == S_RUN) && !fifo_empty && (pops < total);
        last_col   = (SW'(col)   == size_r - SW'(1));
        last_col_d = (SW'(col_d) == size_r - SW'(1));
        prod       = ACC_W'(fifo_data) * ACC_W'(vec[col_d]);
        // Column 0 restarts the row sum instead of clearing acc separately.
        sum        = ((col_d == '0) ? '0 : acc) + prod;
`ifdef ROW_MAC_SAT_EN
        sat_next   = (sum > ACC_W'({RES_W{1'b1}}));
        res_next   = sat_next ? '1 : sum[RES_W-1:0];
`else
        sat_next   = 1'b0;
        res_next   = sum[RES_W-1:0];
`endif
    end

    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            size_r    <= '0;
            pops      <= '0;
            col       <= '0;
            row       <= '0;
            col_d     <= '0;
            row_d     <= '0;
            pop_d     <= 1'b0;
            acc       <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_idx   <= '0;
            res_sat   <= 1'b0;
            done      <= 1'b0;
            for (int unsigned i = 0; i < N; i++) vec[i] <= '0;
        end else begin
            res_valid <= 1'b0;
            done      <= 1'b0;
            pop_d     <= fifo_pop;

            if (vec_wr && state == S_IDLE) vec[vec_idx] <= vec_data;

            if (fifo_pop) begin
                col_d <= col;
                row_d <= row;
                pops  <= pops + PW'(1);
                if (last_col) begin
                    col <= '0;
                    row <= row + IW'(1);
                end else begin
                    col <= col + IW'(1);
                end
            end

            if (pop_d) begin
                acc <= sum;
                if (last_col_d) begin
                    res_valid <= 1'b1;
                    res_data  <= res_next;
                    res_idx   <= row_d;
                    res_sat   <= sat_next;
                end
            end

            case (state)
                S_IDLE: begin
                    if (start) begin
                        size_r <= mat_size;
                        pops   <= '0;
                        col    <= '0;
                        row    <= '0;
                        state  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (total == '0) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end else if (fifo_pop && pops == total - PW'(1)) begin
                        state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // pop_d low means the final element has already been folded into acc.
                    if (!pop_d) begin
                        state <= S_DONE;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_row_mac_sequencer.sv
// Self-checking bench for row_mac_sequencer: FIFO and dot-product reference model kept in the bench.
// Result expectations follow ROW_MAC_SAT_EN when the build defines it.
module tb_row_mac_sequencer;
    localparam int DW = 8, N = 4, RES_W = 16;
    localparam int SW = $clog2(N+1), IW = $clog2(N);

    logic clk, rst, start, vec_wr, fifo_empty, fifo_pop;
    logic res_valid, res_sat, busy, done;
    logic [SW-1:0] mat_size;
    logic [IW-1:0] vec_idx, res_idx;
    logic [DW-1:0] vec_data, fifo_data;
    logic [RES_W-1:0] res_data;

    row_mac_sequencer #(.DW(DW), .N(N), .RES_W(RES_W)) dut (
        .clk(clk), .rst(rst), .start(start), .mat_size(mat_size),
        .vec_wr(vec_wr), .vec_idx(vec_idx), .vec_data(vec_data),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_pop(fifo_pop),
        .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx),
        .res_sat(res_sat), .busy(busy), .done(done)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    int errors = 0, checks = 0;
    int fifo_q[$], mat_m[$];
    int vec_m[N];
    int obs_data[$], obs_idx[$], obs_sat[$], res_cyc[$], pop_cyc[$];
    int done_cnt, done_cyc, viol, pops, busy_after, timed_out;

    function automatic int row_acc(int r, int sz);
        int s = 0;
        for (int c = 0; c < sz; c++) s += mat_m[r*sz + c] * vec_m[c];
        return s;
    endfunction

    function automatic int exp_data(int a);
`ifdef ROW_MAC_SAT_EN
        return (a > (1 << RES_W) - 1) ? (1 << RES_W) - 1 : a;
`else
        return a % (1 << RES_W);
`endif
    endfunction

    function automatic int exp_sat(int a);
`ifdef ROW_MAC_SAT_EN
        return (a > (1 << RES_W) - 1) ? 1 : 0;
`else
        return 0;
`endif
    endfunction

    task automatic write_vec(input int idx, input int val);
        @(posedge clk); #1;
        vec_wr = 1; vec_idx = IW'(idx); vec_data = DW'(val);
        @(posedge clk); #1;
        vec_wr = 0;
        vec_m[idx] = val;
    endtask

    task automatic load_matrix(input int vals[$]);
        fifo_q = vals;
        mat_m  = vals;
    endtask

    // Runs one operation, playing the FIFO side and recording what the DUT does.
    task automatic run_op(input int sz, input int stall_after, input int stall_len,
                          input int stall_pct, input int inject);
        int pending = 0;
        bit prev_pop = 0;
        int stall_left = 0;
        obs_data = {}; obs_idx = {}; obs_sat = {}; res_cyc = {}; pop_cyc = {};
        done_cnt = 0; done_cyc = -1; viol = 0; pops = 0; busy_after = -1; timed_out = 0;
        @(posedge clk); #1;
        fifo_empty = 1; start = 1; mat_size = SW'(sz);
        for (int c = 0; c < 400; c++) begin
            @(posedge clk); #1;
            start = 0; vec_wr = 0;
            if (c == inject) begin
                start = 1; mat_size = SW'(1); vec_wr = 1; vec_idx = '0; vec_data = 8'd99;
            end
            if (prev_pop) fifo_data = DW'(pending);
            fifo_empty = (fifo_q.size() == 0) || (stall_left > 0) ||
                         (stall_pct > 0 && $urandom_range(99) < stall_pct);
            if (stall_left > 0) stall_left--;
            #1;
            if (fifo_pop && (fifo_empty || !busy)) viol++;
            if (!busy && (res_valid || done)) viol++;
            if (res_valid) begin
                obs_data.push_back(int'(res_data));
                obs_idx.push_back(int'(res_idx));
                obs_sat.push_back(int'(res_sat));
                res_cyc.push_back(c);
            end
            if (done) begin done_cnt++; done_cyc = c; end
            prev_pop = fifo_pop;
            if (fifo_pop) begin
                pending = (fifo_q.size() > 0) ? fifo_q.pop_front() : 0;
                pops++;
                pop_cyc.push_back(c);
                if (pops == stall_after) stall_left = stall_len;
            end
            if (done_cyc >= 0 && c == done_cyc + 1) begin
                busy_after = int'(busy);
                break;
            end
        end
        if (done_cyc < 0) timed_out = 1;
        start = 0; vec_wr = 0; fifo_empty = 1;
    endtask

    task automatic test_reset();
        rst = 1; start = 0; mat_size = '0; vec_wr = 0; vec_idx = '0; vec_data = '0;
        fifo_empty = 1; fifo_data = '0;
        for (int i = 0; i < N; i++) vec_m[i] = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({fifo_pop, res_valid, res_data, res_idx, res_sat, busy, done} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got pop=%0b rv=%0b rd=%0d ri=%0d sat=%0b busy=%0b done=%0b, expected all 0",
                     fifo_pop, res_valid, res_data, res_idx, res_sat, busy, done);
        end
        rst = 0;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, res_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_release_idle: got busy/done/rv=%b expected 000", {busy, done, res_valid});
        end
    endtask

    task automatic test_basic();
        write_vec(0, 1); write_vec(1, 2);
        load_matrix('{3, 4, 5, 6});
        run_op(2, -1, 0, 0, -1);
        checks++;
        if (timed_out !== 0) begin errors++; $display("FAIL basic_timeout: got %0d expected 0", timed_out); end
        checks++;
        if (obs_data.size() !== 2) begin errors++; $display("FAIL basic_count: got %0d expected 2", obs_data.size()); end
        if (obs_data.size() == 2) begin
            checks++;
            if (obs_data[0] !== 11 || obs_idx[0] !== 0) begin
                errors++; $display("FAIL basic_row0: got %0d idx %0d expected 11 idx 0", obs_data[0], obs_idx[0]);
            end
            checks++;
            if (obs_data[1] !== 17 || obs_idx[1] !== 1) begin
                errors++; $display("FAIL basic_row1: got %0d idx %0d expected 17 idx 1", obs_data[1], obs_idx[1]);
            end
            checks++;
            if (done_cyc !== res_cyc[1] + 1) begin
                errors++; $display("FAIL basic_done_timing: got cycle %0d expected %0d", done_cyc, res_cyc[1] + 1);
            end
            if (pop_cyc.size() == 4) begin
                checks++;
                if (res_cyc[1] !== pop_cyc[3] + 2) begin
                    errors++; $display("FAIL basic_latency: got cycle %0d expected %0d", res_cyc[1], pop_cyc[3] + 2);
                end
            end
        end
        checks++;
        if (done_cnt !== 1 || busy_after !== 0 || viol !== 0) begin
            errors++;
            $display("FAIL basic_protocol: got done=%0d busy_after=%0d viol=%0d expected 1 0 0", done_cnt, busy_after, viol);
        end
    endtask

    task automatic test_stall();
        load_matrix('{3, 4, 5, 6});
        run_op(2, 2, 3, 0, -1);
        checks++;
        if (viol !== 0 || pops !== 4) begin
            errors++; $display("FAIL stall_pops: got viol=%0d pops=%0d expected 0 4", viol, pops);
        end
        if (pop_cyc.size() == 4) begin
            checks++;
            if (pop_cyc[2] - pop_cyc[1] !== 4) begin
                errors++; $display("FAIL stall_gap: got %0d expected 4", pop_cyc[2] - pop_cyc[1]);
            end
        end
        checks++;
        if (obs_data.size() !== 2) begin errors++; $display("FAIL stall_count: got %0d expected 2", obs_data.size()); end
        else begin
            checks++;
            if (obs_data[0] !== 11 || obs_data[1] !== 17) begin
                errors++; $display("FAIL stall_results: got %0d,%0d expected 11,17", obs_data[0], obs_data[1]);
            end
        end
    endtask

    task automatic test_full();
        int vals[$];
        int want[4] = '{10, 26, 42, 58};
        for (int i = 0; i < N; i++) write_vec(i, 1);
        for (int i = 1; i <= 16; i++) vals.push_back(i);
        load_matrix(vals);
        run_op(4, -1, 0, 0, -1);
        checks++;
        if (pop_cyc.size() !== 16) begin errors++; $display("FAIL full_pops: got %0d expected 16", pop_cyc.size()); end
        else begin
            checks++;
            if (pop_cyc[15] - pop_cyc[0] !== 15) begin
                errors++; $display("FAIL full_consecutive: got span %0d expected 15", pop_cyc[15] - pop_cyc[0]);
            end
        end
        checks++;
        if (obs_data.size() !== 4) begin errors++; $display("FAIL full_count: got %0d expected 4", obs_data.size()); end
        else begin
            for (int r = 0; r < 4; r++) begin
                checks++;
                if (obs_data[r] !== want[r] || obs_idx[r] !== r) begin
                    errors++;
                    $display("FAIL full_row%0d: got %0d idx %0d expected %0d idx %0d", r, obs_data[r], obs_idx[r], want[r], r);
                end
            end
        end
    endtask

    task automatic test_abort();
        int seen = 0;
        @(posedge clk); #1;
        start = 1; mat_size = SW'(4); fifo_empty = 0; fifo_data = 8'd1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            start = 0; fifo_data = DW'(i + 2);
        end
        rst = 1;
        @(posedge clk); #1;
        checks++;
        if ({fifo_pop, res_valid, res_data, res_idx, res_sat, busy, done} !== '0) begin
            errors++;
            $display("FAIL abort_outputs: got pop=%0b rv=%0b rd=%0d ri=%0d sat=%0b busy=%0b done=%0b, expected all 0",
                     fifo_pop, res_valid, res_data, res_idx, res_sat, busy, done);
        end
        rst = 0;
        for (int i = 0; i < N; i++) vec_m[i] = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (done || res_valid || fifo_pop || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL abort_quiet: got %0d active cycles expected 0", seen); end
        fifo_empty = 1;
        write_vec(0, 0);
        load_matrix('{7});
        run_op(1, -1, 0, 0, -1);
        checks++;
        if (obs_data.size() !== 1 || done_cnt !== 1) begin
            errors++; $display("FAIL abort_restart: got %0d results done=%0d expected 1 1", obs_data.size(), done_cnt);
        end else begin
            checks++;
            if (obs_data[0] !== 0 || obs_idx[0] !== 0) begin
                errors++; $display("FAIL abort_restart_value: got %0d idx %0d expected 0 idx 0", obs_data[0], obs_idx[0]);
            end
        end
    endtask

    task automatic test_saturation();
        int vals[$];
        for (int i = 0; i < N; i++) write_vec(i, 255);
        for (int i = 0; i < 16; i++) vals.push_back(255);
        load_matrix(vals);
        run_op(4, -1, 0, 0, -1);
        checks++;
        if (obs_data.size() !== 4) begin errors++; $display("FAIL sat_count: got %0d expected 4", obs_data.size()); end
        else begin
            for (int r = 0; r < 4; r++) begin
                checks++;
                if (obs_data[r] !== exp_data(260100) || obs_sat[r] !== exp_sat(260100)) begin
                    errors++;
                    $display("FAIL sat_row%0d: got %0d sat %0d expected %0d sat %0d",
                             r, obs_data[r], obs_sat[r], exp_data(260100), exp_sat(260100));
                end
            end
        end
    endtask

    task automatic test_busy_ignore();
        write_vec(0, 1); write_vec(1, 2);
        load_matrix('{3, 4, 5, 6});
        run_op(2, -1, 0, 0, 1);
        checks++;
        if (obs_data.size() !== 2 || pops !== 4 || done_cnt !== 1) begin
            errors++;
            $display("FAIL busy_ignore_shape: got res=%0d pops=%0d done=%0d expected 2 4 1", obs_data.size(), pops, done_cnt);
        end else begin
            checks++;
            if (obs_data[0] !== 11 || obs_data[1] !== 17) begin
                errors++; $display("FAIL busy_ignore_results: got %0d,%0d expected 11,17", obs_data[0], obs_data[1]);
            end
        end
        load_matrix('{});
        run_op(0, -1, 0, 0, -1);
        checks++;
        if (obs_data.size() !== 0 || pops !== 0 || done_cnt !== 1 || timed_out !== 0 || busy_after !== 0) begin
            errors++;
            $display("FAIL size0: got res=%0d pops=%0d done=%0d timeout=%0d busy_after=%0d expected 0 0 1 0 0",
                     obs_data.size(), pops, done_cnt, timed_out, busy_after);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 20; it++) begin
            int sz;
            int vals[$];
            sz = $urandom_range(1, N);
            for (int i = 0; i < N; i++) write_vec(i, $urandom_range(255));
            for (int i = 0; i < sz*sz; i++) vals.push_back($urandom_range(255));
            load_matrix(vals);
            run_op(sz, -1, 0, 30, -1);
            checks++;
            if (obs_data.size() !== sz || viol !== 0 || done_cnt !== 1 || pops !== sz*sz) begin
                errors++;
                $display("FAIL rand%0d_shape: got res=%0d viol=%0d done=%0d pops=%0d expected %0d 0 1 %0d",
                         it, obs_data.size(), viol, done_cnt, pops, sz, sz*sz);
            end else begin
                for (int r = 0; r < sz; r++) begin
                    int a;
                    a = row_acc(r, sz);
                    checks++;
                    if (obs_data[r] !== exp_data(a) || obs_idx[r] !== r || obs_sat[r] !== exp_sat(a)) begin
                        errors++;
                        $display("FAIL rand%0d_row%0d: got %0d idx %0d sat %0d expected %0d idx %0d sat %0d",
                                 it, r, obs_data[r], obs_idx[r], obs_sat[r], exp_data(a), r, exp_sat(a));
                    end
                    checks++;
                    if (res_cyc[r] !== pop_cyc[r*sz + sz - 1] + 2) begin
                        errors++;
                        $display("FAIL rand%0d_latency%0d: got cycle %0d expected %0d",
                                 it, r, res_cyc[r], pop_cyc[r*sz + sz - 1] + 2);
                    end
                end
                checks++;
                if (done_cyc !== res_cyc[sz-1] + 1) begin
                    errors++; $display("FAIL rand%0d_done: got cycle %0d expected %0d", it, done_cyc, res_cyc[sz-1] + 1);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_full();
        test_abort();
        test_saturation();
        test_busy_ignore();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
